priority_encoder_seq: RTL and testbench
=======================================

Name: priority_encoder_seq

Overview:
- Registered, parametrised successor to the 8:3 combinational priority encoder.
- Latches request pulses into a sticky pending register and issues one index at a time, highest priority first.
- Each issued index is presented through a valid/ready handshake.
- Sits between peripheral event lines and a single-consumer service/dispatch unit, interrupt-controller style.

Parameters:
- N, 8, number of request lines (N >= 2).
- W, $clog2(N), index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  issue enable; 0 freezes issuing, but pending capture continues.
- req  in  N  request lines, level-sampled each cycle; a 1-cycle pulse is enough.
- mask  in  N  per-line enable; 1 = line eligible for issue.
- out_valid  out  1  y holds an issued index.
- out_ready  in  1  consumer accepts y when out_valid && out_ready.
- y  out  W  issued index; highest eligible bit wins.
- pend  out  N  current pending register, for status read.
- any  out  1  registered OR of (pend & mask).

Behaviour:
- Reset (rst=1 at clk edge): pend=0, out_valid=0, y=0, any=0. No tristate output in any state; y is always driven.
- Pending capture, every cycle: pend_next = (pend & ~clr) | req.
  - clr is one-hot of the index issued this cycle, else 0.
  - Set beats clear: if req[k]=1 in the cycle index k is issued, pend[k] stays 1 and is re-issued later.
- Eligible vector: elig = pend & mask. Masked bits stay pending; they are neither lost nor issued.
- Issue condition: en && (elig != 0) && (!out_valid || out_ready). On issue, at the next edge:
  - y <= index of highest set bit of elig;
  - out_valid <= 1;
  - pend[y] cleared, subject to set-beats-clear.
- Accept without issue: out_valid && out_ready with no issue condition -> out_valid <= 0; y holds its last value.
- Hold: while out_valid && !out_ready, y and out_valid are stable regardless of req, mask or en.
- Back-to-back: a accept and a new issue in the same cycle gives continuous out_valid=1 with a new y the next cycle. Throughput is 1 index/cycle.
- Latency: req pulse at edge t -> pend bit set after edge t -> out_valid/y after edge t+1, i.e. 2 cycles from request to output when idle.
- en=0 with out_valid=1: the held output may still be accepted; no new issue follows.
- mask change takes effect the same cycle (combinational into elig). An already-issued y is not revoked.
- Reset mid-handshake: all state clears, including outstanding y and pending requests; the consumer must discard.
- any is the registered OR of (pend_next & mask_q), one cycle behind mask changes.
- N not a power of 2: indices >= N are never produced.

Optional Feature:
- Macro PRIO_ROUND_ROBIN_EN.
- Undefined: fixed priority; highest index always wins.
- Defined:
  - A W-bit register last (reset 0) records the index issued most recently.
  - The search starts at last-1 and descends with wrap-around (0 wraps to N-1); last itself is checked last. This prevents starvation.
  - last updates only on issue.
  - With a single eligible line, behaviour is identical to fixed mode.

Decomposition:
- Package prio_pkg:
  - default N;
  - function clog2_min1 (returns at least 1);
  - localparam for the one-hot decode of an index.
- Sub-module prio_find (combinational, parameter N):
  - inputs vec[N], and start[W] used only in RR mode;
  - outputs idx[W], found.
- The top level holds pend, output register and handshake logic.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, req=8'hFF -> after release out_valid=0, pend=0, y=0. Release with req=0 -> stays idle.
- Priority order: N=8, mask=8'hFF, out_ready=1, single-cycle req=8'b1010_0100 -> y=7? No: y sequence 7,5,2 on consecutive cycles starting 2 cycles after req; out_valid then drops; pend returns to 0.
- Backpressure: req=8'h12, out_ready=0 for 5 cycles -> y=4 held, out_valid=1, pend=8'h02 throughout. out_ready=1 -> y=1 next cycle, then idle.
- Mask/enable: req=8'h81, mask=8'h01 -> y=0 issued, pend=8'h80 retained. en=0 then mask=8'hFF -> no issue. en=1 -> y=7.
- Set-beats-clear: hold req[3]=1 continuously, out_ready=1 -> y=3 every cycle, pend[3] never clears. Drop req -> exactly one more y=3 issued.
- PRIO_ROUND_ROBIN_EN defined: req held 8'h0A, out_ready=1 -> y sequence 3,1,3,1…. The same stimulus without the macro -> y=3 forever.

Source files
------------

// File: rtl/priority_encoder_seq_pkg.sv
// Shared definitions for the sequential priority encoder: default line count,
// index-width helper and the one-hot seed used to turn an index into a clear mask.
package prio_pkg;

  localparam int DEFAULT_N = 8;
  localparam int MAX_N     = 64;

  // Bit 0 set. Shifting this left by an index gives that index's one-hot mask.
  localparam logic [MAX_N-1:0] ONEHOT_LSB = {{(MAX_N-1){1'b0}}, 1'b1};

  // Index width that never collapses to zero bits, even for tiny N.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_encoder_seq_if.sv
// Request/issue bus of the sequential priority encoder.
// slave: the encoder itself. master: the request source plus the consuming dispatch unit.
interface priority_encoder_seq_if
  import prio_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  localparam int W = clog2_min1(N);

  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [N-1:0] pend;
  logic         any;

  modport master (
    output en, req, mask, out_ready,
    input  out_valid, y, pend, any
  );

  modport slave (
    input  en, req, mask, out_ready,
    output out_valid, y, pend, any
  );

endinterface

// File: rtl/priority_encoder_seq_find.sv
// Combinational winner search over an eligible vector.
// Build option PRIO_ROUND_ROBIN_EN: search begins just below 'start' and wraps
// downwards, so 'start' itself is considered last. Otherwise the highest set bit wins.
module prio_find
  import prio_pkg::*;
#(
  parameter  int N = DEFAULT_N,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

`ifdef PRIO_ROUND_ROBIN_EN
  // Scan from the lowest-priority offset up so the closest hit below start overwrites the rest
  always_comb begin
    int pos;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = N; k >= 1; k--) begin
      pos = (int'(start) + N - k) % N;
      if (vec[pos]) begin
        idx   = W'(pos);
        found = 1'b1;
      end
    end
  end
`else
  logic unused_start;
  assign unused_start = ^start;

  // Scan upwards so the highest set bit is the final write
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (vec[k]) begin
        idx   = W'(k);
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: sticky pending register fed by request pulses,
// one index issued per cycle through a valid/ready handshake.
// Build option PRIO_ROUND_ROBIN_EN switches from fixed to rotating priority.
module priority_encoder_seq
  import prio_pkg::*;
#(
  parameter  int N = DEFAULT_N,
  localparam int W = clog2_min1(N)
) (
  input logic                   clk,
  input logic                   rst,
  priority_encoder_seq_if.slave bus
);

  localparam logic [N-1:0] ONE = ONEHOT_LSB[N-1:0];

  logic [N-1:0] pend;
  logic [N-1:0] pend_next;
  logic [N-1:0] mask_q;
  logic [N-1:0] elig;
  logic [N-1:0] clr;
  logic         out_valid;
  logic         any;
  logic         issue;
  logic         found;
  logic [W-1:0] y;
  logic [W-1:0] idx;
  logic [W-1:0] start;

`ifdef PRIO_ROUND_ROBIN_EN
  logic [W-1:0] last;
  assign start = last;
`else
  assign start = '0;
`endif

  prio_find #(.N(N)) u_find (
    .vec   (elig),
    .start (start),
    .idx   (idx),
    .found (found)
  );

  // Decide whether to issue this cycle and fold the issued bit out of pending; a new request on the same line wins
  always_comb begin
    elig      = pend & bus.mask;
    issue     = bus.en && found && (!out_valid || bus.out_ready);
    clr       = issue ? (ONE << idx) : '0;
    pend_next = (pend & ~clr) | bus.req;
  end

  // State update: pending capture, output register with handshake, status flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      mask_q    <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      any       <= 1'b0;
`ifdef PRIO_ROUND_ROBIN_EN
      last      <= '0;
`endif
    end else begin
      pend   <= pend_next;
      mask_q <= bus.mask;
      any    <= |(pend_next & mask_q);
      if (issue) begin
        y         <= idx;
        out_valid <= 1'b1;
`ifdef PRIO_ROUND_ROBIN_EN
        last      <= idx;
`endif
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.y         = y;
  assign bus.pend      = pend;
  assign bus.any       = any;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Bench for priority_encoder_seq: directed scenarios plus random traffic against
// a cycle-level behavioural model. Honours PRIO_ROUND_ROBIN_EN when defined.
module tb_priority_encoder_seq;
  import prio_pkg::*;

  localparam int N = 8;
  localparam int W = clog2_min1(N);

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [N-1:0] m_pend;
  logic [N-1:0] m_maskq;
  logic         m_valid;
  logic         m_any;
  logic [W-1:0] m_y;
`ifdef PRIO_ROUND_ROBIN_EN
  logic [W-1:0] m_last;
`endif

  priority_encoder_seq_if #(.N(N)) bus();

  priority_encoder_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and move the reference model forward by the same edge
  task automatic tick();
    logic [N-1:0] elig;
    logic [N-1:0] nxt;
    int           pick;
    bit           iss;
`ifdef PRIO_ROUND_ROBIN_EN
    int           p;
`endif
    elig = m_pend & bus.mask;
    pick = -1;
`ifdef PRIO_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      p = (int'(m_last) + N - k) % N;
      if (pick < 0 && elig[p]) pick = p;
    end
`else
    for (int k = N - 1; k >= 0; k--) begin
      if (pick < 0 && elig[k]) pick = k;
    end
`endif
    iss = bus.en && (pick >= 0) && (!m_valid || bus.out_ready);
    nxt = m_pend;
    if (iss) nxt[pick] = 1'b0;
    nxt = nxt | bus.req;
    @(posedge clk);
    if (rst) begin
      m_pend  = '0;
      m_maskq = '0;
      m_valid = 1'b0;
      m_any   = 1'b0;
      m_y     = '0;
`ifdef PRIO_ROUND_ROBIN_EN
      m_last  = '0;
`endif
    end else begin
      m_any   = |(nxt & m_maskq);
      m_maskq = bus.mask;
      m_pend  = nxt;
      if (iss) begin
        m_y     = W'(pick);
        m_valid = 1'b1;
`ifdef PRIO_ROUND_ROBIN_EN
        m_last  = W'(pick);
`endif
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 8'hFF; bus.mask = 8'hFF; bus.en = 1'b1; bus.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.pend !== 8'h00 || bus.y !== 3'd0 || bus.any !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got v=%b pend=%h y=%0d any=%b, want v=0 pend=00 y=0 any=0",
               bus.out_valid, bus.pend, bus.y, bus.any);
    end
    rst = 1'b0;
    bus.req = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.pend !== 8'h00 || bus.any !== 1'b0 || bus.y !== 3'd0) begin
        errors++;
        $display("[TB] FAIL idle_after_reset c%0d: got v=%b pend=%h y=%0d any=%b, want idle",
                 c, bus.out_valid, bus.pend, bus.y, bus.any);
      end
    end
  endtask

  task automatic test_priority();
    logic [N-1:0] reqs [6] = '{8'hA4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bit           ev   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int           ey   [6] = '{0, 7, 5, 2, 2, 2};
    logic [N-1:0] ep   [6] = '{8'hA4, 8'h24, 8'h04, 8'h00, 8'h00, 8'h00};
    bus.mask = 8'hFF; bus.en = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.req = reqs[c];
      tick();
      checks++;
      if (bus.out_valid !== ev[c] || (ev[c] && bus.y !== W'(ey[c])) || bus.pend !== ep[c]) begin
        errors++;
        $display("[TB] FAIL priority c%0d: got v=%b y=%0d pend=%h, want v=%b y=%0d pend=%h",
                 c, bus.out_valid, bus.y, bus.pend, ev[c], ey[c], ep[c]);
      end
      checks++;
      if ({bus.out_valid, bus.y, bus.pend, bus.any} !== {m_valid, m_y, m_pend, m_any}) begin
        errors++;
        $display("[TB] FAIL priority_model c%0d: got v=%b y=%0d pend=%h any=%b, want v=%b y=%0d pend=%h any=%b",
                 c, bus.out_valid, bus.y, bus.pend, bus.any, m_valid, m_y, m_pend, m_any);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] reqs [9] = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bit           rdy  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit           ev   [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int           ey   [9] = '{0, 4, 4, 4, 4, 4, 1, 1, 1};
    logic [N-1:0] ep   [9] = '{8'h12, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00};
    bus.mask = 8'hFF; bus.en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.req = reqs[c];
      bus.out_ready = rdy[c];
      tick();
      checks++;
      if (bus.out_valid !== ev[c] || (ev[c] && bus.y !== W'(ey[c])) || bus.pend !== ep[c]) begin
        errors++;
        $display("[TB] FAIL backpressure c%0d: got v=%b y=%0d pend=%h, want v=%b y=%0d pend=%h",
                 c, bus.out_valid, bus.y, bus.pend, ev[c], ey[c], ep[c]);
      end
      checks++;
      if ({bus.out_valid, bus.y, bus.pend, bus.any} !== {m_valid, m_y, m_pend, m_any}) begin
        errors++;
        $display("[TB] FAIL backpressure_model c%0d: got v=%b y=%0d pend=%h any=%b, want v=%b y=%0d pend=%h any=%b",
                 c, bus.out_valid, bus.y, bus.pend, bus.any, m_valid, m_y, m_pend, m_any);
      end
    end
  endtask

  task automatic test_mask_enable();
    logic [N-1:0] reqs [7] = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [N-1:0] msk  [7] = '{8'h01, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bit           ens  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit           ev   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int           ey   [7] = '{0, 0, 0, 0, 0, 7, 7};
    logic [N-1:0] ep   [7] = '{8'h81, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00};
    bus.out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.req = reqs[c];
      bus.mask = msk[c];
      bus.en = ens[c];
      tick();
      checks++;
      if (bus.out_valid !== ev[c] || (ev[c] && bus.y !== W'(ey[c])) || bus.pend !== ep[c]) begin
        errors++;
        $display("[TB] FAIL mask_enable c%0d: got v=%b y=%0d pend=%h, want v=%b y=%0d pend=%h",
                 c, bus.out_valid, bus.y, bus.pend, ev[c], ey[c], ep[c]);
      end
      checks++;
      if ({bus.out_valid, bus.y, bus.pend, bus.any} !== {m_valid, m_y, m_pend, m_any}) begin
        errors++;
        $display("[TB] FAIL mask_enable_model c%0d: got v=%b y=%0d pend=%h any=%b, want v=%b y=%0d pend=%h any=%b",
                 c, bus.out_valid, bus.y, bus.pend, bus.any, m_valid, m_y, m_pend, m_any);
      end
    end
  endtask

  task automatic test_set_beats_clear();
    bit           ev [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [N-1:0] ep [9] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00};
    bus.mask = 8'hFF; bus.en = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.req = (c < 6) ? 8'h08 : 8'h00;
      tick();
      checks++;
      if (bus.out_valid !== ev[c] || (ev[c] && bus.y !== 3'd3) || bus.pend !== ep[c]) begin
        errors++;
        $display("[TB] FAIL set_beats_clear c%0d: got v=%b y=%0d pend=%h, want v=%b y=3 pend=%h",
                 c, bus.out_valid, bus.y, bus.pend, ev[c], ep[c]);
      end
      checks++;
      if ({bus.out_valid, bus.y, bus.pend, bus.any} !== {m_valid, m_y, m_pend, m_any}) begin
        errors++;
        $display("[TB] FAIL set_beats_clear_model c%0d: got v=%b y=%0d pend=%h any=%b, want v=%b y=%0d pend=%h any=%b",
                 c, bus.out_valid, bus.y, bus.pend, bus.any, m_valid, m_y, m_pend, m_any);
      end
    end
  endtask

  task automatic test_rotation();
    int exp_y;
    rst = 1'b1;
    bus.req = 8'h00;
    tick();
    rst = 1'b0;
    bus.mask = 8'hFF; bus.en = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.req = (c < 8) ? 8'h0A : 8'h00;
      tick();
      if (c >= 1 && c < 8) begin
`ifdef PRIO_ROUND_ROBIN_EN
        exp_y = (c % 2 == 1) ? 3 : 1;
`else
        exp_y = 3;
`endif
        checks++;
        if (bus.out_valid !== 1'b1 || bus.y !== W'(exp_y)) begin
          errors++;
          $display("[TB] FAIL rotation c%0d: got v=%b y=%0d, want v=1 y=%0d", c, bus.out_valid, bus.y, exp_y);
        end
      end
      checks++;
      if ({bus.out_valid, bus.y, bus.pend, bus.any} !== {m_valid, m_y, m_pend, m_any}) begin
        errors++;
        $display("[TB] FAIL rotation_model c%0d: got v=%b y=%0d pend=%h any=%b, want v=%b y=%0d pend=%h any=%b",
                 c, bus.out_valid, bus.y, bus.pend, bus.any, m_valid, m_y, m_pend, m_any);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.req       = N'($urandom & $urandom & $urandom);
      bus.mask      = N'($urandom | $urandom);
      bus.en        = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if ({bus.out_valid, bus.y, bus.pend, bus.any} !== {m_valid, m_y, m_pend, m_any}) begin
        errors++;
        $display("[TB] FAIL random c%0d: got v=%b y=%0d pend=%h any=%b, want v=%b y=%0d pend=%h any=%b",
                 c, bus.out_valid, bus.y, bus.pend, bus.any, m_valid, m_y, m_pend, m_any);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.mask = '0; bus.en = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_priority();
    test_backpressure();
    test_mask_enable();
    test_set_beats_clear();
    test_rotation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
